// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow, asynchronous square
// wave in clk cycles. One result per input period, flagged by a 1-cycle strobe.
// A sticky timeout reports a stalled input.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;   // synchronised level, one cycle behind s
  logic                   s_dd_q;  // previous value of s_d_q
  logic                   lvl;
  logic                   rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // Synchroniser plus two delay flops. Edge detection runs on the delayed
  // pair so the FSM acts on a registered edge; this sets the strobe latency
  // to SYNC_STAGES+2 cycles from the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      s_dd_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
      s_dd_q <= s_d_q;
    end
  end

  assign lvl  = s_d_q;
  assign rise = s_d_q & ~s_dd_q;

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: en low wins; a rise beats the saturation/timeout check.
  // The high counter only advances while the level is high, so it stops by
  // itself after the falling edge and restarts on the next rise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (lvl) hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule
